// File: rtl/serial_link_pkg.sv
// Shared constants and types for the byte scheduler feeding the serial link.
package serial_link_pkg;

  localparam int unsigned BITS_PER_BYTE = 8;
  localparam logic [7:0]  COMMA_BYTE    = 8'hBC;

  typedef enum logic {
    SYNC,
    RUN
  } link_state_t;

endpackage

// File: rtl/serial_tx_scheduler_if.sv
// Requester handshake and serializer-facing bus of the serial TX scheduler.
interface serial_tx_scheduler_if #(
  parameter int unsigned NUM_REQ = 4
);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ack;
  logic [7:0]           tx_byte;
  logic                 tx_load;
  logic                 tx_is_comma;
  logic                 link_active;

  modport master (
    output req_valid, req_data,
    input  req_ack, tx_byte, tx_load, tx_is_comma, link_active
  );

  modport slave (
    input  req_valid, req_data,
    output req_ack, tx_byte, tx_load, tx_is_comma, link_active
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant searching from rr_ptr upward,
// pointer advances past the winner whenever the grant is taken.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk_8f,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [IDX_W-1:0]   grant_idx_c,
  output logic               any_c
);

  logic [IDX_W-1:0] rr_ptr;

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    any_c       = 1'b0;
    grant_idx_c = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!any_c && req[IDX_W'((32'(rr_ptr) + k) % NUM_REQ)]) begin
        any_c       = 1'b1;
        grant_idx_c = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
      end
    end
    grant_c = any_c ? (NUM_REQ'(1) << grant_idx_c) : '0;
  end

  always_ff @(posedge clk_8f) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (advance && any_c) begin
      rr_ptr <= (grant_idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_c + IDX_W'(1);
    end
  end

endmodule

// File: rtl/serial_tx_scheduler.sv
// Byte scheduler for the serial lane: training commas after reset, then round-robin
// requester bytes one per 8 bit clocks, with idle and periodic forced commas.
module serial_tx_scheduler
  import serial_link_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned SYNC_COMMAS = 4,
  parameter int unsigned MAX_RUN     = 16
) (
  input  logic                  clk_8f,
  input  logic                  reset,
  serial_tx_scheduler_if.slave  bus
);

  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned BIT_W  = $clog2(BITS_PER_BYTE);
  localparam int unsigned SYNC_W = $clog2(SYNC_COMMAS + 1);
  localparam int unsigned RUN_W  = $clog2(MAX_RUN + 1);

  link_state_t        state, state_d;
  logic [BIT_W-1:0]   bit_cnt;
  logic [SYNC_W-1:0]  sync_cnt, sync_cnt_d;
  logic [RUN_W-1:0]   run_cnt, run_cnt_d;
  logic [7:0]         tx_byte_d;
  logic               tx_is_comma_d;
  logic               tx_load_d;
  logic [NUM_REQ-1:0] req_ack_d;
  logic               link_active_d;
  logic               slot_c;
  logic               grant_take_c;

  logic [NUM_REQ-1:0] grant_c;
  logic [IDX_W-1:0]   grant_idx_c;
  logic               any_c;
  logic [7:0]         req_bytes [NUM_REQ];

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk_8f      (clk_8f),
    .reset       (reset),
    .req         (bus.req_valid),
    .advance     (grant_take_c),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c),
    .any_c       (any_c)
  );

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_bytes[i] = bus.req_data[8*i +: 8];
    end
  end

  assign slot_c = (bit_cnt == BIT_W'(BITS_PER_BYTE - 1));

  // Next state and next outputs; everything only moves on a slot edge.
  always_comb begin
    state_d       = state;
    sync_cnt_d    = sync_cnt;
    run_cnt_d     = run_cnt;
    tx_byte_d     = bus.tx_byte;
    tx_is_comma_d = bus.tx_is_comma;
    tx_load_d     = 1'b0;
    req_ack_d     = '0;
    grant_take_c  = 1'b0;
    if (slot_c) begin
      tx_load_d     = 1'b1;
      tx_byte_d     = COMMA_BYTE;
      tx_is_comma_d = 1'b1;
      case (state)
        SYNC: begin
          sync_cnt_d = sync_cnt + SYNC_W'(1);
          if (sync_cnt_d == SYNC_W'(SYNC_COMMAS)) begin
            state_d = RUN;
          end
        end
        RUN: begin
          // Forced comma takes priority so the receiver never loses alignment.
          if (run_cnt == RUN_W'(MAX_RUN)) begin
            run_cnt_d = '0;
          end else if (any_c) begin
            grant_take_c  = 1'b1;
            tx_byte_d     = req_bytes[grant_idx_c];
            tx_is_comma_d = 1'b0;
            req_ack_d     = grant_c;
            run_cnt_d     = run_cnt + RUN_W'(1);
          end else begin
            run_cnt_d = '0;
          end
        end
        default: state_d = SYNC;
      endcase
    end
    link_active_d = (state_d == RUN);
  end

  always_ff @(posedge clk_8f) begin
    if (reset) begin
      bit_cnt         <= BIT_W'(BITS_PER_BYTE - 1);
      state           <= SYNC;
      sync_cnt        <= '0;
      run_cnt         <= '0;
      bus.tx_byte     <= COMMA_BYTE;
      bus.tx_is_comma <= 1'b1;
      bus.tx_load     <= 1'b0;
      bus.req_ack     <= '0;
      bus.link_active <= 1'b0;
    end else begin
      bit_cnt         <= bit_cnt + BIT_W'(1);
      state           <= state_d;
      sync_cnt        <= sync_cnt_d;
      run_cnt         <= run_cnt_d;
      bus.tx_byte     <= tx_byte_d;
      bus.tx_is_comma <= tx_is_comma_d;
      bus.tx_load     <= tx_load_d;
      bus.req_ack     <= req_ack_d;
      bus.link_active <= link_active_d;
    end
  end

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Randomized bench for serial_tx_scheduler: slot-level reference model plus a
// serialize/deserialize scoreboard of every byte handed to the serializer.
module tb_serial_tx_scheduler;

  localparam int unsigned NUM_REQ     = 4;
  localparam int unsigned SYNC_COMMAS = 4;
  localparam int unsigned MAX_RUN     = 16;

  localparam int MODE_IDLE = 0;
  localparam int MODE_ALL  = 1;
  localparam int MODE_ONE1 = 2;
  localparam int MODE_RAND = 3;

  logic clk_8f = 1'b0;
  logic reset  = 1'b1;

  always #5 clk_8f = ~clk_8f;

  serial_tx_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  serial_tx_scheduler #(
    .NUM_REQ     (NUM_REQ),
    .SYNC_COMMAS (SYNC_COMMAS),
    .MAX_RUN     (MAX_RUN)
  ) dut (
    .clk_8f (clk_8f),
    .reset  (reset),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state (slot level)
  int  m_commas;
  int  m_run;
  int  m_ptr;
  bit  m_active;
  int  cnt;
  bit  last_data;

  // Requester state
  int         mode;
  logic [7:0] rd [NUM_REQ];
  bit         rv [NUM_REQ];
  bit         ack_pend [NUM_REQ];

  // Serializer / deserializer scoreboard
  logic [7:0] exp_q [$];
  logic [7:0] ser_sh;
  int         ser_left;
  logic [7:0] rx_sh;
  int         rx_n;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] rnd_byte();
    if ($urandom_range(0, 7) == 0) return 8'hBC;
    return 8'($urandom);
  endfunction

  task automatic model_reset();
    m_commas = 0;
    m_run    = 0;
    m_ptr    = 0;
    m_active = 1'b0;
    cnt      = 0;
    last_data = 1'b0;
    exp_q.delete();
    ser_left = 0;
    rx_n     = 0;
  endtask

  task automatic model_slot();
    logic [7:0]         eb;
    bit                 ec;
    logic [NUM_REQ-1:0] ea;
    int                 g;
    eb = 8'hBC;
    ec = 1'b1;
    ea = '0;
    if (!m_active) begin
      m_commas++;
      if (m_commas == int'(SYNC_COMMAS)) m_active = 1'b1;
    end else if (m_run == int'(MAX_RUN)) begin
      m_run = 0;
    end else begin
      g = -1;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        if (g < 0 && rv[(m_ptr + k) % int'(NUM_REQ)]) g = (m_ptr + k) % int'(NUM_REQ);
      end
      if (g >= 0) begin
        eb    = rd[g];
        ec    = 1'b0;
        ea[g] = 1'b1;
        m_ptr = (g + 1) % int'(NUM_REQ);
        m_run++;
      end else begin
        m_run = 0;
      end
    end
    last_data = !ec;
    check_val("slot_tx_byte", 32'(bus.tx_byte), 32'(eb));
    check_val("slot_is_comma", 32'(bus.tx_is_comma), 32'(ec));
    check_val("slot_tx_load", 32'(bus.tx_load), 32'd1);
    check_val("slot_req_ack", 32'(bus.req_ack), 32'(ea));
    check_val("slot_link_active", 32'(bus.link_active), 32'(m_active));
    exp_q.push_back(eb);
  endtask

  task automatic serdes_step();
    logic b;
    if (bus.tx_load) begin
      ser_sh   = bus.tx_byte;
      ser_left = 8;
    end
    if (ser_left > 0) begin
      b        = ser_sh[7];
      ser_sh   = {ser_sh[6:0], 1'b0};
      ser_left--;
      rx_sh    = {rx_sh[6:0], b};
      rx_n++;
      if (rx_n == 8) begin
        rx_n = 0;
        check_val("serdes_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check_val("serdes_byte", 32'(rx_sh), 32'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic drive_reqs();
    logic [8*NUM_REQ-1:0] pd;
    logic [NUM_REQ-1:0]   pv;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (bus.req_ack[i]) begin
        ack_pend[i] = 1'b1;
      end else if (ack_pend[i]) begin
        ack_pend[i] = 1'b0;
        case (mode)
          MODE_ALL:  begin rv[i] = 1'b1; rd[i] = 8'(8'h11 * (i + 1)); end
          MODE_ONE1: begin rv[i] = (i == 1); rd[i] = rnd_byte(); end
          MODE_RAND: begin rv[i] = $urandom_range(0, 1) == 1; rd[i] = rnd_byte(); end
          default:   rv[i] = 1'b0;
        endcase
      end else begin
        case (mode)
          MODE_ALL: if (!rv[i]) begin rv[i] = 1'b1; rd[i] = 8'(8'h11 * (i + 1)); end
          MODE_ONE1: begin
            if (i != 1) rv[i] = 1'b0;
            else if (!rv[i]) begin rv[i] = 1'b1; rd[i] = rnd_byte(); end
          end
          MODE_RAND: begin
            if (!rv[i]) begin
              if ($urandom_range(0, 3) == 0) begin rv[i] = 1'b1; rd[i] = rnd_byte(); end
            end else if ($urandom_range(0, 39) == 0) begin
              rv[i] = 1'b0;
            end
          end
          default: rv[i] = 1'b0;
        endcase
      end
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      pv[i]         = rv[i];
      pd[8*i +: 8]  = rd[i];
    end
    bus.req_valid = pv;
    bus.req_data  = pd;
  endtask

  // One bit clock: check outputs of the edge just taken, then drive requesters.
  task automatic step();
    @(negedge clk_8f);
    if (reset) begin
      check_val("rst_tx_byte", 32'(bus.tx_byte), 32'h0000_00BC);
      check_val("rst_is_comma", 32'(bus.tx_is_comma), 32'd1);
      check_val("rst_tx_load", 32'(bus.tx_load), 32'd0);
      check_val("rst_req_ack", 32'(bus.req_ack), 32'd0);
      check_val("rst_link_active", 32'(bus.link_active), 32'd0);
      model_reset();
    end else begin
      cnt++;
      if (((cnt - 1) % 8) == 0) begin
        model_slot();
      end else begin
        check_val("gap_load_ack", 32'({bus.tx_load, bus.req_ack}), 32'd0);
      end
      serdes_step();
    end
    drive_reqs();
  endtask

  task automatic run_slots(input int n);
    repeat (n * 8) step();
  endtask

  initial begin
    bit found;
    mode = MODE_IDLE;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      rv[i]       = 1'b0;
      rd[i]       = 8'h00;
      ack_pend[i] = 1'b0;
    end
    bus.req_valid = '0;
    bus.req_data  = '0;
    model_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    run_slots(8);
    mode = MODE_ALL;
    run_slots(12);
    mode = MODE_ONE1;
    run_slots(40);
    mode = MODE_RAND;
    run_slots(150);

    // Reset in the middle of a data byte, with requesters left pending through SYNC
    found = 1'b0;
    for (int n = 0; n < 800 && !found; n++) begin
      step();
      if (last_data && cnt > 0 && ((cnt - 1) % 8) == 3) found = 1'b1;
    end
    check_val("mid_reset_found", 32'(found), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    mode = MODE_ONE1;
    run_slots(8);
    mode = MODE_RAND;
    run_slots(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
